// File: rtl/histogram_overlay_renderer_if.sv
// Purpose : raster/RAM/pixel signal bundle for histogram_overlay_renderer.
// Signals : iValid, iFrameStart, X_Cont, Y_Cont  - raster position and frame pulse
//           iHistoValue, oHistoAddr               - histogram RAM read port (1-cycle latency)
//           iMaxValue, iThreshPoint, iMode        - normalisation input and render controls
//           oPixel, oMarker, oValid, oBusy        - rendered planes, marker, valid, scan busy
// Modports: master = raster/RAM side driving the renderer, slave = renderer.
interface histogram_overlay_renderer_if #(
    parameter int BIN_BITS = 8,
    parameter int COUNT_W  = 20,
    parameter int NUM_CH   = 3,
    parameter int PIX_W    = 8
);
    logic                        iValid;
    logic                        iFrameStart;
    logic [15:0]                 X_Cont;
    logic [15:0]                 Y_Cont;
    logic [NUM_CH*COUNT_W-1:0]   iHistoValue;
    logic [COUNT_W-1:0]          iMaxValue;
    logic [BIN_BITS-1:0]         iThreshPoint;
    logic                        iMode;
    logic [BIN_BITS-1:0]         oHistoAddr;
    logic [NUM_CH*PIX_W-1:0]     oPixel;
    logic                        oMarker;
    logic                        oBusy;
    logic                        oValid;

    modport master (
        output iValid, iFrameStart, X_Cont, Y_Cont, iHistoValue, iMaxValue, iThreshPoint, iMode,
        input  oHistoAddr, oPixel, oMarker, oBusy, oValid
    );

    modport slave (
        input  iValid, iFrameStart, X_Cont, Y_Cont, iHistoValue, iMaxValue, iThreshPoint, iMode,
        output oHistoAddr, oPixel, oMarker, oBusy, oValid
    );
endinterface

// File: rtl/histogram_overlay_renderer.sv
// Purpose : renders one horizontal histogram bar per raster line for NUM_CH channels.
//           Bars start at ORIGIN_X and grow toward smaller X; bin 0 sits on line ORIGIN_Y.
//           Bar length = count >> active shift, saturated to 2^LEN_BITS. The shift is found
//           by a serial leading-one scan of the frame max and applied from the next frame on.
// Ports   : iClk - pixel clock
//           iRst - asynchronous active-high reset
//           bus  - slave modport of histogram_overlay_renderer_if (raster in, RAM port,
//                  pixel planes / marker / valid / busy out, 2-cycle pixel latency)
//
// state | meaning
// IDLE  | no scan running, pending shift stable
// SCAN  | walking r_idx down from COUNT_W-1 looking for the max's leading one
// DONE  | leading one found (or idx 0 reached); load pending shift
module histogram_overlay_renderer #(
    parameter int BIN_BITS = 8,
    parameter int COUNT_W  = 20,
    parameter int NUM_CH   = 3,
    parameter int PIX_W    = 8,
    parameter int LEN_BITS = 8,
    parameter int ORIGIN_X = 800,
    parameter int ORIGIN_Y = 383
) (
    input  logic                          iClk,
    input  logic                          iRst,
    histogram_overlay_renderer_if.slave   bus
);
    localparam int SH_W  = $clog2(COUNT_W + 1);
    localparam int IDX_W = $clog2(COUNT_W);
    localparam int TOP_W = IDX_W + 1;
    localparam int BAR_LEN = 2 ** LEN_BITS;
    localparam logic [15:0] OX = 16'(ORIGIN_X);
    localparam logic [15:0] OY = 16'(ORIGIN_Y);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [COUNT_W-1:0]   r_max;
    logic [IDX_W-1:0]     r_idx;
    logic [SH_W-1:0]      r_active_shift;
    logic [SH_W-1:0]      r_pending_shift;

    logic                 r_s1_inside;
    logic [LEN_BITS-1:0]  r_s1_d;
    logic [BIN_BITS-1:0]  r_s1_bin;
    logic                 r_s1_valid;
    logic                 r_s1_mode;
    logic [BIN_BITS-1:0]  r_s1_thresh;

    logic [NUM_CH*PIX_W-1:0] r_pixel;
    logic                 r_marker;
    logic                 r_valid;

    // Differences are only meaningful when the matching <= test holds, so no wrap is seen.
    logic [15:0]          w_dy;
    logic [15:0]          w_dx;
    logic                 w_in_y;
    logic                 w_in_x;
    logic [TOP_W-1:0]     w_top;
    logic [SH_W-1:0]      w_new_shift;
    logic [NUM_CH*PIX_W-1:0] w_pix;

    assign w_dy   = OY - bus.Y_Cont;
    assign w_dx   = OX - bus.X_Cont;
    assign w_in_y = (bus.Y_Cont <= OY) && ({1'b0, w_dy} < 17'(2 ** BIN_BITS));
    assign w_in_x = (bus.X_Cont <= OX) && ({1'b0, w_dx} < 17'(BAR_LEN));
    assign bus.oHistoAddr = w_dy[BIN_BITS-1:0];

    // Leading-one position + 1 is the bit count of the max; keep LEN_BITS of them.
    assign w_top       = TOP_W'(r_idx) + TOP_W'(1);
    assign w_new_shift = ((r_max != '0) && (w_top > TOP_W'(LEN_BITS)))
                         ? SH_W'(w_top - TOP_W'(LEN_BITS)) : '0;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [COUNT_W-1:0]  w_shifted;
            logic [LEN_BITS:0]   w_len;
            logic [LEN_BITS:0]   w_d_ext;
            logic                w_hit;

            assign w_shifted = bus.iHistoValue[c*COUNT_W +: COUNT_W] >> r_active_shift;
            assign w_len     = (w_shifted > COUNT_W'(BAR_LEN)) ? (LEN_BITS+1)'(BAR_LEN)
                                                              : w_shifted[LEN_BITS:0];
            assign w_d_ext   = {1'b0, r_s1_d};
            // Outline mode lights only the last pixel of the bar.
            assign w_hit     = r_s1_mode ? ((w_len != '0) && (w_d_ext == w_len - (LEN_BITS+1)'(1)))
                                         : (w_d_ext < w_len);
            assign w_pix[c*PIX_W +: PIX_W] = {PIX_W{r_s1_inside & w_hit}};
        end
    endgenerate

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_s1_inside <= 1'b0;
            r_s1_d      <= '0;
            r_s1_bin    <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_mode   <= 1'b0;
            r_s1_thresh <= '0;
            r_pixel     <= '0;
            r_marker    <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_s1_inside <= w_in_x & w_in_y;
            r_s1_d      <= w_dx[LEN_BITS-1:0];
            r_s1_bin    <= w_dy[BIN_BITS-1:0];
            r_s1_valid  <= bus.iValid;
            r_s1_mode   <= bus.iMode;
            r_s1_thresh <= bus.iThreshPoint;
            r_pixel     <= w_pix;
            r_marker    <= r_s1_inside && (r_s1_bin == r_s1_thresh);
            r_valid     <= r_s1_valid;
        end
    end

    // A frame start always wins: it promotes the last completed result and restarts the scan,
    // so an interrupted scan never reaches the pending shift.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state         <= S_IDLE;
            r_max           <= '0;
            r_idx           <= '0;
            r_active_shift  <= '0;
            r_pending_shift <= '0;
        end else if (bus.iFrameStart) begin
            r_active_shift <= r_pending_shift;
            r_max          <= bus.iMaxValue;
            r_idx          <= IDX_W'(COUNT_W - 1);
            r_state        <= S_SCAN;
        end else begin
            case (r_state)
                S_SCAN: begin
                    if (r_max[r_idx] || (r_idx == '0)) r_state <= S_DONE;
                    else                               r_idx   <= r_idx - IDX_W'(1);
                end
                S_DONE: begin
                    r_pending_shift <= w_new_shift;
                    r_state         <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.oPixel  = r_pixel;
    assign bus.oMarker = r_marker;
    assign bus.oValid  = r_valid;
    assign bus.oBusy   = (r_state == S_SCAN);
endmodule

// File: tb/tb_histogram_overlay_renderer.sv
module tb_histogram_overlay_renderer;
    localparam int BIN_BITS = 8;
    localparam int COUNT_W  = 20;
    localparam int NUM_CH   = 3;
    localparam int PIX_W    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    histogram_overlay_renderer_if #(.BIN_BITS(BIN_BITS), .COUNT_W(COUNT_W),
                                    .NUM_CH(NUM_CH), .PIX_W(PIX_W)) bus();

    histogram_overlay_renderer dut (.iClk(clk), .iRst(rst), .bus(bus));

    // Histogram RAM: registered read, data one cycle after the address.
    logic [NUM_CH*COUNT_W-1:0] ram [256];
    always @(posedge clk) bus.iHistoValue <= ram[bus.oHistoAddr];

    typedef struct {
        logic [23:0] pix;
        logic        mk;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst && bus.oValid === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: oValid high at cycle %0d, required no output", cyc);
                end else begin
                    e = sbq.pop_front();
                    if (bus.oPixel !== e.pix || bus.oMarker !== e.mk || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL %s: got pixel=%h marker=%b cycle=%0d, required pixel=%h marker=%b cycle=%0d",
                                 e.name, bus.oPixel, bus.oMarker, cyc, e.pix, e.mk, e.cyc);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic pix(input logic [15:0] x, input logic [15:0] y, input logic m,
                       input logic [7:0] thr, input logic [23:0] ep, input logic em,
                       input string nm);
        @(negedge clk);
        bus.iValid       = 1'b1;
        bus.X_Cont       = x;
        bus.Y_Cont       = y;
        bus.iMode        = m;
        bus.iThreshPoint = thr;
        sbq.push_back('{pix: ep, mk: em, cyc: cyc + 2, name: nm});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.iValid = 1'b0;
        end
    endtask

    task automatic frame(input logic [COUNT_W-1:0] mx);
        @(negedge clk);
        bus.iValid      = 1'b0;
        bus.iFrameStart = 1'b1;
        bus.iMaxValue   = mx;
        @(negedge clk);
        bus.iFrameStart = 1'b0;
    endtask

    // Called just after the frame-start edge; counts cycles with oBusy high.
    task automatic busy_len(input int req, input string nm);
        int n;
        n = 0;
        while (bus.oBusy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        chk(nm, n, req);
    endtask

    localparam logic [7:0] NT = 8'd200;   // threshold bin never drawn on the lines used

    initial begin : stim
        for (int i = 0; i < 256; i++) ram[i] = '0;
        bus.iValid = 0; bus.iFrameStart = 0; bus.X_Cont = 0; bus.Y_Cont = 0;
        bus.iMaxValue = 0; bus.iThreshPoint = 0; bus.iMode = 0;

        repeat (2) @(negedge clk);
        chk("rst_pixel",  bus.oPixel,  0);
        chk("rst_valid",  bus.oValid,  0);
        chk("rst_busy",   bus.oBusy,   0);
        chk("rst_marker", bus.oMarker, 0);
        rst = 1'b0;

        ram[0] = {20'd0, 20'd0, 20'd800};
        frame(20'd1500);
        busy_len(10, "busy_1500");
        // active shift still 0: count 800 saturates to a 256-pixel bar
        pix(16'd701, 16'd383, 0, NT, 24'h0000FF, 0, "s0_x701");
        pix(16'd700, 16'd383, 0, NT, 24'h0000FF, 0, "s0_x700");
        pix(16'd544, 16'd383, 0, NT, 24'h000000, 0, "x544_out");
        pix(16'd801, 16'd383, 0, NT, 24'h000000, 0, "x801_out");
        idle(3);

        frame(20'd200);          // activates shift 3
        busy_len(13, "busy_200");
        pix(16'd701, 16'd383, 0, NT, 24'h0000FF, 0, "sh3_x701");
        pix(16'd700, 16'd383, 0, NT, 24'h000000, 0, "sh3_x700");
        pix(16'd701, 16'd383, 1, NT, 24'h0000FF, 0, "ol_x701");
        pix(16'd702, 16'd383, 1, NT, 24'h000000, 0, "ol_x702");
        pix(16'd700, 16'd383, 1, NT, 24'h000000, 0, "ol_x700");
        ram[255] = {20'hFFFFF, 20'd0, 20'd0};
        pix(16'd545, 16'd128, 0, NT, 24'hFF0000, 0, "y128_in");
        pix(16'd790, 16'd127, 0, NT, 24'h000000, 0, "y127_out");
        pix(16'd790, 16'd384, 0, NT, 24'h000000, 0, "y384_out");
        pix(16'd790, 16'd378, 0, 8'd5, 24'h000000, 1, "marker");
        pix(16'd790, 16'd378, 1, 8'd5, 24'h000000, 1, "ol_zero_marker");
        pix(16'd790, 16'd379, 0, 8'd5, 24'h000000, 0, "marker_off");
        idle(3);

        frame(20'd0);            // activates shift 0 from the max=200 scan
        busy_len(20, "busy_0");
        ram[255] = {20'd0, 20'd0, 20'hFFFFF};
        pix(16'd545, 16'd128, 0, NT, 24'h0000FF, 0, "sat_d255");
        pix(16'd545, 16'd128, 1, NT, 24'h0000FF, 0, "sat_outline");
        pix(16'd546, 16'd128, 1, NT, 24'h000000, 0, "sat_outline_d254");
        idle(3);

        frame(20'd1500);
        @(negedge clk);
        chk("busy_mid_scan", bus.oBusy, 1);
        frame(20'h80000);        // restart three cycles into the scan
        busy_len(1, "busy_restart");
        ram[0] = {20'd0, 20'd20480, 20'd800};
        pix(16'd700, 16'd383, 0, NT, 24'h00FFFF, 0, "keep_shift0");
        idle(3);

        frame(20'd0);            // activates shift 12
        busy_len(20, "busy_0_b");
        pix(16'd800, 16'd383, 0, NT, 24'h00FF00, 0, "sh12_x800");
        pix(16'd796, 16'd383, 0, NT, 24'h00FF00, 0, "sh12_x796");
        pix(16'd795, 16'd383, 0, NT, 24'h000000, 0, "sh12_x795");
        pix(16'd796, 16'd383, 1, NT, 24'h00FF00, 0, "sh12_ol_x796");
        pix(16'd797, 16'd383, 1, NT, 24'h000000, 0, "sh12_ol_x797");
        idle(3);

        frame(20'd1500);         // shift 0 again, scan in progress
        for (int i = 0; i < 4; i++)
            pix(16'd797, 16'd383, 0, NT, 24'h00FFFF, 0, "pre_rst");
        @(negedge clk);
        chk("pre_rst_busy",  bus.oBusy,  1);
        chk("pre_rst_valid", bus.oValid, 1);
        rst = 1'b1;
        bus.iValid = 1'b0;
        sbq.delete();
        #1;
        chk("rst_mid_pixel",  bus.oPixel,  0);
        chk("rst_mid_valid",  bus.oValid,  0);
        chk("rst_mid_busy",   bus.oBusy,   0);
        chk("rst_mid_marker", bus.oMarker, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pix(16'd700, 16'd383, 0, NT, 24'h00FFFF, 0, "post_rst_shift0");
        frame(20'd1500);
        pix(16'd700, 16'd383, 0, NT, 24'h00FFFF, 0, "post_rst_frame");
        idle(5);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
